hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 16-bit five-stage core. Tracks destination-register state of the instructions in EX and MEM, and produces the registered `forwardA`/`forwardB` select codes consumed by the execute stage. Also generates load-use stalls and branch/jump redirect bubbles, and keeps saturating stall and flush counters for performance debug.

---
 rtl/core_pkg.sv | 31 +++
 rtl/hazard_ctrl_fwd_sel.sv | 22 ++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the five-stage core: forward select codes, the
// pipeline slot record used by hazard tracking, and the GPR specifier width.
package core_pkg;

  localparam int REG_W = 3;

  typedef logic [2:0] fwd_t;

  localparam fwd_t FWD_RF       = 3'b000;
  localparam fwd_t FWD_MEMWB    = 3'b001;
  localparam fwd_t FWD_EXMEM    = 3'b010;
  localparam fwd_t FWD_EXMEM_PC = 3'b011;
  localparam fwd_t FWD_MEMWB_PC = 3'b100;

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [REG_W-1:0] wr_reg;
    logic             is_load;
    logic             is_link;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // True when the slot holds a live GPR write that a used source depends on.
  function automatic logic slotWrites(input slot_t s, input logic [REG_W-1:0] src,
                                      input logic used);
    return used && s.valid && s.wr_en && (s.wr_reg == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forward select: compares one source specifier against the EX
// and MEM slots, the newer EX producer winning.
module fwd_sel
  import core_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic             used_i,
  input  slot_t            exSlot_i,
  input  slot_t            memSlot_i,
  output fwd_t             fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (slotWrites(exSlot_i, src_i, used_i)) begin
      fwd_o = exSlot_i.is_link ? FWD_EXMEM_PC : FWD_EXMEM;
    end else if (slotWrites(memSlot_i, src_i, used_i)) begin
      fwd_o = memSlot_i.is_link ? FWD_MEMWB_PC : FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: tracks EX/MEM destination state, registers operand
// forward selects, raises load-use stalls and redirect bubbles, counts both.
module hazard_ctrl #(
  parameter int REG_W = core_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             id_is_link,
  input  logic             ex_redirect,
  input  logic             mem_stall,
  input  logic             cnt_clr,
  output logic [2:0]       forwardA,
  output logic [2:0]       forwardB,
  output logic             stall_pc,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import core_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  slot_t            exSlot_q, exSlot_d;
  slot_t            memSlot_q, memSlot_d;
  fwd_t             fwdA_q, fwdA_d;
  fwd_t             fwdB_q, fwdB_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  fwd_t fwdRs, fwdRt;
  logic loadUse, advance, redirect, bubble, stallBubble;

  fwd_sel uFwdRs (
    .src_i     (id_rs),
    .used_i    (id_rs_used),
    .exSlot_i  (exSlot_q),
    .memSlot_i (memSlot_q),
    .fwd_o     (fwdRs)
  );

  fwd_sel uFwdRt (
    .src_i     (id_rt),
    .used_i    (id_rt_used),
    .exSlot_i  (exSlot_q),
    .memSlot_i (memSlot_q),
    .fwd_o     (fwdRt)
  );

  // A redirect squashes the dependent instruction, so it swallows load-use.
  always_comb begin
    loadUse     = id_valid && exSlot_q.is_load &&
                  (slotWrites(exSlot_q, id_rs, id_rs_used) ||
                   slotWrites(exSlot_q, id_rt, id_rt_used));
    advance     = !mem_stall;
    redirect    = advance && ex_redirect;
    stallBubble = advance && loadUse && !redirect;
    bubble      = redirect || stallBubble;
  end

  assign stall_pc    = rst_n && (mem_stall || stallBubble);
  assign ifid_flush  = rst_n && redirect;
  assign idex_bubble = rst_n && bubble;

  always_comb begin
    exSlot_d   = exSlot_q;
    memSlot_d  = memSlot_q;
    fwdA_d     = fwdA_q;
    fwdB_d     = fwdB_q;
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;

    if (advance) begin
      memSlot_d = exSlot_q;
      if (bubble) begin
        exSlot_d = SLOT_EMPTY;
        fwdA_d   = FWD_RF;
        fwdB_d   = FWD_RF;
      end else begin
        exSlot_d.valid   = id_valid;
        exSlot_d.wr_en   = id_wr_en;
        exSlot_d.wr_reg  = id_wr_reg;
        exSlot_d.is_load = id_is_load;
        exSlot_d.is_link = id_is_link;
        fwdA_d           = fwdRs;
        fwdB_d           = fwdRt;
      end
    end

    if (cnt_clr) begin
      stallCnt_d = '0;
      flushCnt_d = '0;
    end else begin
      if (stallBubble && (stallCnt_q != CNT_MAX)) stallCnt_d = stallCnt_q + 1'b1;
      if (redirect && (flushCnt_q != CNT_MAX))    flushCnt_d = flushCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exSlot_q   <= SLOT_EMPTY;
      memSlot_q  <= SLOT_EMPTY;
      fwdA_q     <= FWD_RF;
      fwdB_q     <= FWD_RF;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      exSlot_q   <= exSlot_d;
      memSlot_q  <= memSlot_d;
      fwdA_q     <= fwdA_d;
      fwdB_q     <= fwdB_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign forwardA  = fwdA_q;
  assign forwardB  = fwdB_q;
  assign stall_cnt = stallCnt_q;
  assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle model plus directed constants
// feed a scoreboard queue that is drained against the DUT every cycle.
module tb_hazard_ctrl;

  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, id_is_link;
  logic [2:0]  id_rs, id_rt, id_wr_reg;
  logic        ex_redirect, mem_stall, cnt_clr;
  logic [2:0]  forwardA, forwardB;
  logic        stall_pc, ifid_flush, idex_bubble;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.REG_W(3), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .id_wr_en    (id_wr_en),
    .id_wr_reg   (id_wr_reg),
    .id_is_load  (id_is_load),
    .id_is_link  (id_is_link),
    .ex_redirect (ex_redirect),
    .mem_stall   (mem_stall),
    .cnt_clr     (cnt_clr),
    .forwardA    (forwardA),
    .forwardB    (forwardB),
    .stall_pc    (stall_pc),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } sbEntry_t;

  sbEntry_t sbQueue[$];
  int       compared   = 0;
  int       mismatched = 0;

  slot_t       mEx, mMem;
  logic [2:0]  mFwdA, mFwdB;
  logic [15:0] mStallCnt, mFlushCnt;
  logic        mLoadUse, mRedirect;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      0:       return {13'd0, forwardA};
      1:       return {13'd0, forwardB};
      2:       return {15'd0, stall_pc};
      3:       return {15'd0, ifid_flush};
      4:       return {15'd0, idex_bubble};
      5:       return stall_cnt;
      6:       return flush_cnt;
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic expectVal(input string tag, input int sel, input logic [15:0] val);
    sbQueue.push_back('{tag: tag, sel: sel, val: val});
  endtask

  function automatic logic [2:0] mdlFwd(input logic [2:0] src, input logic used);
    if (used && mEx.valid && mEx.wr_en && mEx.wr_reg == src)
      return mEx.is_link ? 3'b011 : 3'b010;
    if (used && mMem.valid && mMem.wr_en && mMem.wr_reg == src)
      return mMem.is_link ? 3'b100 : 3'b001;
    return 3'b000;
  endfunction

  task automatic modelReset();
    mEx       = '0;
    mMem      = '0;
    mFwdA     = 3'b000;
    mFwdB     = 3'b000;
    mStallCnt = 16'd0;
    mFlushCnt = 16'd0;
  endtask

  // Drive one cycle of ID/EX inputs and queue what the model expects to see.
  task automatic applyStimulus(input logic idv, input logic [2:0] rs, input logic [2:0] rt,
                               input logic rsU, input logic rtU, input logic wr,
                               input logic [2:0] wreg, input logic ld, input logic lk,
                               input logic redir, input logic ms, input logic clr);
    @(negedge clk);
    id_valid = idv;  id_rs = rs;  id_rt = rt;  id_rs_used = rsU;  id_rt_used = rtU;
    id_wr_en = wr;   id_wr_reg = wreg;  id_is_load = ld;  id_is_link = lk;
    ex_redirect = redir;  mem_stall = ms;  cnt_clr = clr;
    mLoadUse  = idv && mEx.valid && mEx.wr_en && mEx.is_load &&
                ((rsU && rs == mEx.wr_reg) || (rtU && rt == mEx.wr_reg));
    mRedirect = redir && !ms;
    expectVal("mdl_fwdA",   0, {13'd0, mFwdA});
    expectVal("mdl_fwdB",   1, {13'd0, mFwdB});
    expectVal("mdl_stall",  2, {15'd0, ms || (mLoadUse && !mRedirect)});
    expectVal("mdl_flush",  3, {15'd0, mRedirect});
    expectVal("mdl_bubble", 4, {15'd0, !ms && (mRedirect || mLoadUse)});
    expectVal("mdl_scnt",   5, mStallCnt);
    expectVal("mdl_fcnt",   6, mFlushCnt);
  endtask

  // Compare everything queued for this cycle, then step the model past the edge.
  task automatic drainScoreboard();
    sbEntry_t   e;
    logic [2:0] nA, nB;
    #2;
    while (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkOutput(e.tag, observe(e.sel), e.val);
    end
    nA = mdlFwd(id_rs, id_rs_used);
    nB = mdlFwd(id_rt, id_rt_used);
    if (cnt_clr) begin
      mStallCnt = 16'd0;
      mFlushCnt = 16'd0;
    end else begin
      if (!mem_stall && mLoadUse && !mRedirect && mStallCnt != 16'hFFFF) mStallCnt++;
      if (mRedirect && mFlushCnt != 16'hFFFF) mFlushCnt++;
    end
    if (!mem_stall) begin
      mMem = mEx;
      if (mRedirect || mLoadUse) begin
        mEx   = '0;
        mFwdA = 3'b000;
        mFwdB = 3'b000;
      end else begin
        mEx.valid   = id_valid;
        mEx.wr_en   = id_wr_en;
        mEx.wr_reg  = id_wr_reg;
        mEx.is_load = id_is_load;
        mEx.is_link = id_is_link;
        mFwdA       = nA;
        mFwdB       = nB;
      end
    end
  endtask

  task automatic writer(input logic [2:0] wreg, input logic ld, input logic lk);
    applyStimulus(1, 0, 0, 0, 0, 1, wreg, ld, lk, 0, 0, 0);
    drainScoreboard();
  endtask

  task automatic bubbleSlot();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_wr_en = 0; id_wr_reg = 0; id_is_load = 0; id_is_link = 0;
    ex_redirect = 0; mem_stall = 0; cnt_clr = 0;
    modelReset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bubbleSlot();
    expectVal("rst_fwdA", 0, 16'd0);
    expectVal("rst_fwdB", 1, 16'd0);
    expectVal("rst_scnt", 5, 16'd0);
    expectVal("rst_fcnt", 6, 16'd0);
    drainScoreboard();

    // ALU producer in EX forwards its result to the next instruction's rs
    writer(3'd1, 0, 0);
    applyStimulus(1, 3'd1, 3'd5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    expectVal("add_nostall", 2, 16'd0);
    drainScoreboard();
    bubbleSlot();
    expectVal("add_fwdA", 0, 16'd2);
    expectVal("add_fwdB", 1, 16'd0);
    drainScoreboard();

    // Load-use through rt: one bubble, then writeback forwarding
    writer(3'd2, 1, 0);
    applyStimulus(1, 3'd0, 3'd2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    expectVal("lu_stall",  2, 16'd1);
    expectVal("lu_bubble", 4, 16'd1);
    expectVal("lu_flush",  3, 16'd0);
    drainScoreboard();
    applyStimulus(1, 3'd0, 3'd2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    expectVal("lu_released", 2, 16'd0);
    expectVal("lu_scnt",     5, 16'd1);
    drainScoreboard();
    bubbleSlot();
    expectVal("lu_fwdB", 1, 16'd1);
    expectVal("lu_fwdA", 0, 16'd0);
    drainScoreboard();

    // Link writer: nextPC from EX/MEM, then from MEM/WB one slot later
    writer(3'd7, 0, 1);
    applyStimulus(1, 3'd7, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drainScoreboard();
    bubbleSlot();
    expectVal("jal_ex_fwdA", 0, 16'd3);
    drainScoreboard();
    writer(3'd7, 0, 1);
    writer(3'd4, 0, 0);
    applyStimulus(1, 3'd7, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drainScoreboard();
    bubbleSlot();
    expectVal("jal_mem_fwdA", 0, 16'd4);
    drainScoreboard();

    // Same register in both slots: newer wins; unused source never forwards
    writer(3'd3, 0, 0);
    writer(3'd3, 0, 0);
    applyStimulus(1, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drainScoreboard();
    bubbleSlot();
    expectVal("newer_fwdA", 0, 16'd2);
    drainScoreboard();
    writer(3'd3, 0, 0);
    writer(3'd3, 0, 0);
    applyStimulus(1, 3'd3, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drainScoreboard();
    bubbleSlot();
    expectVal("unused_fwdA", 0, 16'd0);
    drainScoreboard();

    // Redirect coinciding with load-use
    writer(3'd2, 1, 0);
    applyStimulus(1, 3'd0, 3'd2, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    expectVal("rd_lu_flush",  3, 16'd1);
    expectVal("rd_lu_bubble", 4, 16'd1);
    expectVal("rd_lu_stall",  2, 16'd0);
    drainScoreboard();
    bubbleSlot();
    expectVal("rd_lu_fcnt", 6, 16'd1);
    expectVal("rd_lu_scnt", 5, 16'd1);
    drainScoreboard();

    // mem_stall freezes everything while a redirect waits
    writer(3'd3, 0, 0);
    applyStimulus(1, 3'd3, 3'd0, 1, 0, 1, 3'd5, 0, 0, 0, 0, 0);
    drainScoreboard();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 3'd0, 3'd5, 0, 1, 0, 0, 0, 0, 1, 1, 0);
      expectVal("ms_stall",  2, 16'd1);
      expectVal("ms_flush",  3, 16'd0);
      expectVal("ms_bubble", 4, 16'd0);
      expectVal("ms_fwdA",   0, 16'd2);
      expectVal("ms_fwdB",   1, 16'd0);
      expectVal("ms_fcnt",   6, 16'd1);
      drainScoreboard();
    end
    applyStimulus(1, 3'd0, 3'd5, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    expectVal("ms_accept_flush", 3, 16'd1);
    expectVal("ms_accept_stall", 2, 16'd0);
    drainScoreboard();
    bubbleSlot();
    expectVal("ms_accept_fcnt", 6, 16'd2);
    expectVal("ms_accept_fwdB", 1, 16'd0);
    drainScoreboard();

    // Back-to-back redirects up to saturation, then clear
    for (int i = 0; i < 65533; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      drainScoreboard();
    end
    bubbleSlot();
    expectVal("sat_reach", 6, 16'hFFFF);
    drainScoreboard();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drainScoreboard();
    bubbleSlot();
    expectVal("sat_hold", 6, 16'hFFFF);
    drainScoreboard();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drainScoreboard();
    bubbleSlot();
    expectVal("clr_fcnt", 6, 16'd0);
    expectVal("clr_scnt", 5, 16'd0);
    drainScoreboard();

    // Reset asserted in the middle of a load-use stall
    writer(3'd2, 1, 0);
    applyStimulus(1, 3'd0, 3'd2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    expectVal("pre_rst_stall", 2, 16'd1);
    drainScoreboard();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_stall",  {15'd0, stall_pc},    16'd0);
    checkOutput("rst_mid_bubble", {15'd0, idex_bubble}, 16'd0);
    checkOutput("rst_mid_flush",  {15'd0, ifid_flush},  16'd0);
    checkOutput("rst_mid_fwdA",   {13'd0, forwardA},    16'd0);
    checkOutput("rst_mid_fwdB",   {13'd0, forwardB},    16'd0);
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    writer(3'd2, 1, 0);
    applyStimulus(1, 3'd0, 3'd2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    expectVal("post_rst_stall", 2, 16'd1);
    drainScoreboard();
    bubbleSlot();
    drainScoreboard();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
